mcpu_mem_responder: RTL and testbench
=====================================

MCPU_MEM_RESPONDER -- requirements
Module: mcpu_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: request address width (64-byte space).
REQ-002 SHALL have parameter DATA_W, default 8: data width.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: initiator request, held with all request fields stable until rsp_ack.
REQ-006 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, ADDR_W: access address.
REQ-008 SHALL have port req_wdata, input, DATA_W: write data.
REQ-009 SHALL have port rsp_ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, DATA_W: read data; valid with rsp_ack and held until the next read's ack.
REQ-011 SHALL have port busy, output, 1: high while in any state other than IDLE.
REQ-012 SHALL have port ld_en, input, 1: host preload write strobe.
REQ-013 SHALL have port ld_addr, input, ADDR_W: preload address.
REQ-014 SHALL have port ld_data, input, DATA_W: preload data.
REQ-015 SHALL have port cfg_wait, input, 2: wait states per access (used only per REQ-030).

Function
REQ-016 SHALL hold a 2**ADDR_W x DATA_W memory in flops.
REQ-017 SHALL use states IDLE, WAIT, RESP.
REQ-018 IDLE: req_valid=1 and ld_en=0 SHALL latch req_we/addr/wdata and load the wait counter with the effective wait; go to WAIT if the effective wait is nonzero, else RESP.
REQ-019 WAIT: SHALL decrement the counter each cycle and go to RESP when it reaches 1.
REQ-020 RESP: SHALL assert rsp_ack for exactly this cycle, perform the write (req_we=1) or register mem[addr] into rsp_rdata (req_we=0), then return to IDLE.
REQ-021 Latency: request sampled in IDLE at cycle N -> rsp_ack at cycle N+1+wait.
REQ-022 Back-to-back: req_valid high in IDLE on the cycle after RESP SHALL be accepted as a new request; there are no idle bubbles beyond that IDLE cycle.
REQ-023 Write to address A completing at cycle N SHALL be visible to a read of A accepted at cycle N+1.
REQ-024 ld_en=1 SHALL write ld_data to mem[ld_addr] on that edge in any state.
REQ-025 ld_en=1 and req_valid=1 in IDLE SHALL block acceptance that cycle; the loader has priority and the request is accepted on the first IDLE cycle with ld_en=0.
REQ-026 ld_en write and RESP write to the same address in the same cycle: the RESP write SHALL win.
REQ-027 Writes SHALL leave rsp_rdata unchanged.
REQ-028 Addresses wrap naturally; every ADDR_W value is valid and there is no error response.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, rsp_ack=0, rsp_rdata=0, busy=0, wait counter=0, and all memory bytes=0x00; an in-flight access SHALL be dropped without ack.

Configuration
REQ-030 Macro MCPU_MEM_WAIT_EN defined: effective wait = cfg_wait (0..3).
REQ-031 Macro MCPU_MEM_WAIT_EN undefined: effective wait = 0, cfg_wait is ignored, the WAIT state and counter are not built, and latency is fixed at 1 cycle.

Structure
REQ-032 Package mcpu_mem_pkg SHALL hold the state enum type, ADDR_W/DATA_W defaults and the DEPTH constant.
REQ-033 Sub-module mcpu_mem_array SHALL implement the storage: two write ports with RESP priority, one registered-read source and asynchronous clear; the FSM stays in mcpu_mem_responder.

Verification
REQ-034 Reset then read addr 0x05 -> rsp_ack one cycle after acceptance, rsp_rdata=0x00, busy high for exactly 1 cycle.
REQ-035 Write 0xA5 to 0x3F, then immediately read 0x3F -> rsp_rdata=0xA5; rsp_rdata unchanged during the write ack.
REQ-036 With MCPU_MEM_WAIT_EN and cfg_wait=3, read -> rsp_ack 4 cycles after acceptance; without the macro, the same stimulus acks after 1 cycle.
REQ-037 ld_en with ld_addr=0x10, ld_data=0x5A asserted for 2 cycles while req_valid is high -> acceptance delayed 2 cycles; a subsequent read of 0x10 returns 0x5A.
REQ-038 rst_n pulsed low while in WAIT -> no rsp_ack, all memory reads 0x00, and the next request completes normally.

Source files
------------

// File: rtl/mcpu_mem_pkg.sv
// mcpu_mem_pkg: shared types and constants for the memory responder slice.
//   state_e      : responder FSM states (IDLE, WAIT, RESP)
//   ADDR_W_DEF   : default request address width
//   DATA_W_DEF   : default data width
//   DEPTH        : word count of the default-sized array
package mcpu_mem_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mcpu_mem_array.sv
// mcpu_mem_array: flop-based 2**ADDR_W x DATA_W storage.
//   clk, rst_n          : clock, async active-low clear of every word and rd_q
//   ld_en/ld_addr/ld_data : host preload write port (lower priority)
//   wr_en/wr_addr/wr_data : responder write port (wins on address collision)
//   rd_addr             : read address; rd_data is the combinational word
//   rd_en               : captures mem[rd_addr] into rd_q on the edge
//   rd_q                : registered read data, held between rd_en pulses
module mcpu_mem_array
  import mcpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_q
);
  localparam int WORDS = 2 ** ADDR_W;

  logic [WORDS-1:0][DATA_W-1:0] mem;

  assign rd_data = mem[rd_addr];

  // Read samples pre-edge contents; the later wr_en assignment overrides ld_en
  // when both target the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      rd_q <= '0;
    end else begin
      if (rd_en) rd_q <= mem[rd_addr];
      if (ld_en) mem[ld_addr] <= ld_data;
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end
endmodule

// File: rtl/mcpu_mem_responder.sv
// mcpu_mem_responder: single-initiator memory responder with host preload.
//   clk, rst_n       : clock, async active-low reset
//   req_valid/we/addr/wdata : request, held stable until rsp_ack
//   rsp_ack          : one-cycle completion pulse (RESP state)
//   rsp_rdata        : read data, valid with rsp_ack, held until next read ack
//   busy             : FSM not in IDLE
//   ld_en/ld_addr/ld_data : host preload, any state, blocks acceptance in IDLE
//   cfg_wait         : wait states per access, only with MCPU_MEM_WAIT_EN
// Macro MCPU_MEM_WAIT_EN: builds the WAIT state and counter; otherwise the
// access latency is fixed at one cycle and cfg_wait is ignored.
module mcpu_mem_responder
  import mcpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        cfg_wait
);
  state_e state, state_nx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_data, rd_q;

  assign accept = (state == IDLE) && req_valid && !ld_en;

`ifdef MCPU_MEM_WAIT_EN
  logic [1:0] cnt_q, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_nx;
  end
`else
  logic unused_cfg_wait;
  assign unused_cfg_wait = ^cfg_wait;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
`ifdef MCPU_MEM_WAIT_EN
    cnt_nx = cnt_q;
`endif
    case (state)
      IDLE: if (accept) begin
`ifdef MCPU_MEM_WAIT_EN
        cnt_nx   = cfg_wait;
        state_nx = (cfg_wait != 2'd0) ? WAIT : RESP;
`else
        state_nx = RESP;
`endif
      end
`ifdef MCPU_MEM_WAIT_EN
      // Counter was loaded with the wait count; leave on the cycle it reads 1
      // so exactly cfg_wait WAIT cycles elapse.
      WAIT: begin
        cnt_nx = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_nx = RESP;
      end
`endif
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_ack = (state == RESP);
  assign busy    = (state != IDLE);
  assign wr_en   = rsp_ack && we_q;
  assign rd_en   = rsp_ack && !we_q;

  // During a read ack present the live word; rd_q captures it on the same
  // edge and holds it afterwards, so writes never disturb rsp_rdata.
  assign rsp_rdata = rd_en ? rd_data : rd_q;

  mcpu_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wr_en   (wr_en),
    .wr_addr (addr_q),
    .wr_data (wdata_q),
    .rd_en   (rd_en),
    .rd_addr (addr_q),
    .rd_data (rd_data),
    .rd_q    (rd_q)
  );
endmodule

// File: tb/tb_mcpu_mem_responder.sv
// tb_mcpu_mem_responder: directed plus randomized checks of mcpu_mem_responder
// against an array-based memory model and the access latency rule.
module tb_mcpu_mem_responder;
  logic       clk, rst_n;
  logic       req_valid, req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ack;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       ld_en;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] cfg_wait;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_m [64];
  logic [7:0] last_rd;

  mcpu_mem_responder #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_ack   (rsp_ack),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .cfg_wait  (cfg_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eff(input logic [1:0] cw);
`ifdef MCPU_MEM_WAIT_EN
    return int'(cw);
`else
    return 0 * int'(cw);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  // Called at a negedge. Leaves req_valid high at the ack negedge so a
  // following call exercises back-to-back acceptance.
  task automatic access(input logic we, input logic [5:0] a, input logic [7:0] d,
                        input logic [1:0] cw, input int nld,
                        input logic [5:0] la, input logic [7:0] ldd);
    int cnt;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; cfg_wait = cw;
    if (busy) begin
      @(posedge clk); @(negedge clk);
      chk("idle_between", {31'd0, busy}, 32'd0);
    end
    if (nld > 0) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldd;
      for (int i = 0; i < nld; i++) begin
        @(posedge clk);
        mem_m[la] = ldd;
        @(negedge clk);
        chk("ld_blocks_accept", {31'd0, busy}, 32'd0);
      end
      ld_en = 1'b0;
    end
    @(posedge clk);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      chk("busy_inflight", {31'd0, busy}, 32'd1);
    end while (!rsp_ack && cnt < 10);
    chk("latency", cnt, eff(cw) + 1);
    if (we) begin
      chk("wr_keeps_rdata", {24'd0, rsp_rdata}, {24'd0, last_rd});
      mem_m[a] = d;
    end else begin
      chk("rd_data", {24'd0, rsp_rdata}, {24'd0, mem_m[a]});
      last_rd = mem_m[a];
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack", {31'd0, rsp_ack}, 32'd0);
    chk("idle_rdata_hold", {24'd0, rsp_rdata}, {24'd0, last_rd});
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; cfg_wait = 2'd0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, rsp_ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read of a cleared word after reset, busy exactly one cycle at wait 0.
    access(1'b0, 6'h05, 8'h00, 2'd0, 0, 6'h00, 8'h00);
    idle();

    // Write then immediate read of the top address.
    access(1'b1, 6'h3F, 8'hA5, 2'd0, 0, 6'h00, 8'h00);
    access(1'b0, 6'h3F, 8'h00, 2'd0, 0, 6'h00, 8'h00);
    chk("rd_3f_a5", {24'd0, rsp_rdata}, 32'hA5);
    idle();

    // Maximum wait setting.
    access(1'b0, 6'h3F, 8'h00, 2'd3, 0, 6'h00, 8'h00);
    idle();

    // Loader holds off the request two cycles, then the read sees its data.
    access(1'b0, 6'h10, 8'h00, 2'd0, 2, 6'h10, 8'h5A);
    access(1'b0, 6'h10, 8'h00, 2'd1, 0, 6'h00, 8'h00);
    chk("rd_10_5a", {24'd0, rsp_rdata}, 32'h5A);
    idle();

    // Loader and responder write the same word on the RESP edge: RESP wins.
    access(1'b1, 6'h22, 8'h3C, 2'd0, 0, 6'h00, 8'h00);
    req_valid = 1'b0; ld_en = 1'b1; ld_addr = 6'h22; ld_data = 8'hC3;
    @(posedge clk); @(negedge clk);
    ld_en = 1'b0;
    access(1'b0, 6'h22, 8'h00, 2'd0, 0, 6'h00, 8'h00);
    chk("collision_resp_wins", {24'd0, rsp_rdata}, 32'h3C);
    idle();

    // Randomized mix over a small address window to force RAW hits.
    for (int n = 0; n < 60; n++) begin
      access(1'($urandom), 6'($urandom_range(0, 15)), 8'($urandom), 2'($urandom),
             $urandom_range(0, 2), 6'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    // Reset during an in-flight access: no ack, memory cleared.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h03; cfg_wait = 2'd3;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, rsp_ack}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_rdata", {24'd0, rsp_rdata}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_hold_ack", {31'd0, rsp_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 64; i++)
      access(1'b0, 6'(i), 8'h00, 2'($urandom), 0, 6'h00, 8'h00);
    idle();
    access(1'b1, 6'h07, 8'h99, 2'd2, 0, 6'h00, 8'h00);
    access(1'b0, 6'h07, 8'h00, 2'd0, 0, 6'h00, 8'h00);
    chk("post_rst_rw", {24'd0, rsp_rdata}, 32'h99);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
